// File: rtl/parking_gate_scheduler.sv
// Round-robin gate scheduler for the uni and general entry and exit lanes of a parking barrier.
// Each request is arbitrated, checked against zone capacity, then acked or denied, and an ack
// opens the barrier for OPEN_CYCLES cycles.
module parking_gate_scheduler #(
  parameter int unsigned OPEN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  input  logic [9:0] uni_parked_car,
  input  logic [9:0] parked_car,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic [3:0] ack,
  output logic [3:0] deny,
  output logic       gate_open,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StCheck, StOpen, StClose} state_e;

  state_e     state_q, state_d;
  logic [1:0] g_q, g_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic       car_entered_d, is_uni_car_entered_d;
  logic       car_exited_d, is_uni_car_exited_d;
  logic [3:0] ack_d, deny_d;
  logic       gate_open_d, busy_d;

  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       eligible;

  // Round-robin search: ptr+1 first, ptr itself last.
  always_comb begin
    pick  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    eligible = 1'b0;
    unique case (g_q)
      2'd0: eligible = uni_is_vacated_space;
      2'd1: eligible = is_vacated_space;
      2'd2: eligible = (uni_parked_car != 10'd0);
      2'd3: eligible = (parked_car != 10'd0);
      default: eligible = 1'b0;
    endcase
  end

  always_comb begin
    state_d              = state_q;
    g_d                  = g_q;
    ptr_d                = ptr_q;
    cnt_d                = cnt_q;
    car_entered_d        = 1'b0;
    is_uni_car_entered_d = 1'b0;
    car_exited_d         = 1'b0;
    is_uni_car_exited_d  = 1'b0;
    ack_d                = 4'b0000;
    deny_d               = 4'b0000;
    gate_open_d          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req != 4'b0000) begin
          g_d     = pick;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!req[g_q]) begin
          // Requester withdrew: no response and the pointer stays put.
          state_d = StIdle;
        end else begin
          ptr_d = g_q;
          if (eligible) begin
            ack_d       = 4'b0001 << g_q;
            gate_open_d = 1'b1;
            cnt_d       = 8'(OPEN_CYCLES);
            state_d     = StOpen;
            unique case (g_q)
              2'd0: begin
                car_entered_d        = 1'b1;
                is_uni_car_entered_d = 1'b1;
              end
              2'd1: car_entered_d = 1'b1;
              2'd2: begin
                car_exited_d        = 1'b1;
                is_uni_car_exited_d = 1'b1;
              end
              2'd3: car_exited_d = 1'b1;
              default: ;
            endcase
          end else begin
            deny_d  = 4'b0001 << g_q;
            state_d = StIdle;
          end
        end
      end
      StOpen: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = StClose;
        end else begin
          cnt_d       = cnt_q - 8'd1;
          gate_open_d = 1'b1;
        end
      end
      StClose: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= StIdle;
      g_q                <= 2'd0;
      ptr_q              <= 2'd3;
      cnt_q              <= 8'd0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      ack                <= 4'b0000;
      deny               <= 4'b0000;
      gate_open          <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state_q            <= state_d;
      g_q                <= g_d;
      ptr_q              <= ptr_d;
      cnt_q              <= cnt_d;
      car_entered        <= car_entered_d;
      is_uni_car_entered <= is_uni_car_entered_d;
      car_exited         <= car_exited_d;
      is_uni_car_exited  <= is_uni_car_exited_d;
      ack                <= ack_d;
      deny               <= deny_d;
      gate_open          <= gate_open_d;
      busy               <= busy_d;
    end
  end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Randomized bench for parking_gate_scheduler against a per-cycle behavioural model built
// from the scheduler rules: a grant index, a busy-cycle countdown and a round-robin pointer.
module tb_parking_gate_scheduler;

  localparam int unsigned OC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       uni_vac = 1'b0;
  logic       gen_vac = 1'b0;
  logic [9:0] uni_cnt = 10'd0;
  logic [9:0] gen_cnt = 10'd0;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic [3:0] ack, deny;
  logic       gate_open, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pointer, pending check index (-1 if none) and remaining busy cycles.
  int         m_ptr, m_chk, m_t;
  logic [3:0] e_ack, e_deny;
  logic [3:0] e_ev;  // {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}

  parking_gate_scheduler #(.OPEN_CYCLES(OC)) dut (
    .clk                  (clk),
    .reset                (rst_n),
    .req                  (req),
    .uni_is_vacated_space (uni_vac),
    .is_vacated_space     (gen_vac),
    .uni_parked_car       (uni_cnt),
    .parked_car           (gen_cnt),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .ack                  (ack),
    .deny                 (deny),
    .gate_open            (gate_open),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_elig(input int g);
    case (g)
      0: return uni_vac;
      1: return gen_vac;
      2: return uni_cnt != 10'd0;
      default: return gen_cnt != 10'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_ptr = 3; m_chk = -1; m_t = 0;
    e_ack = '0; e_deny = '0; e_ev = '0;
  endtask

  // One rising edge of the reference behaviour, using inputs stable since the last negedge.
  task automatic m_step();
    e_ack = '0; e_deny = '0; e_ev = '0;
    if (m_chk >= 0) begin
      int g = m_chk;
      m_chk = -1;
      if (req[g]) begin
        m_ptr = g;
        if (m_elig(g)) begin
          e_ack[g] = 1'b1;
          case (g)
            0: e_ev = 4'b1100;
            1: e_ev = 4'b1000;
            2: e_ev = 4'b0011;
            default: e_ev = 4'b0010;
          endcase
          m_t = OC + 1;  // OC open cycles plus the closing cycle
        end else begin
          e_deny[g] = 1'b1;
        end
      end
    end else if (m_t > 0) begin
      m_t--;
    end else if (req != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        int i = (m_ptr + k) % 4;
        if (m_chk < 0 && req[i]) m_chk = i;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("ack", 16'(ack), 16'(e_ack));
    check_eq("deny", 16'(deny), 16'(e_deny));
    check_eq("events", 16'({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}),
             16'(e_ev));
    check_eq("gate_open", 16'(gate_open), 16'(m_t > 1));
    check_eq("busy", 16'(busy), 16'((m_chk >= 0) || (m_t > 0)));
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 2) == 0) req = 4'($urandom);
    // Requesters usually drop once answered.
    if ($urandom_range(0, 1) == 0) req = req & ~(ack | deny);
    uni_vac = ($urandom_range(0, 3) != 0);
    gen_vac = ($urandom_range(0, 3) != 0);
    uni_cnt = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
    gen_cnt = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
  endtask

  initial begin
    m_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Uni entry with space, then hold into the open phase.
    req = 4'b0001; uni_vac = 1'b1; gen_vac = 1'b0; uni_cnt = 10'd0; gen_cnt = 10'd5;
    cycle();
    cycle();
    req = 4'b0000;
    cycle();
    // Asynchronous reset mid-open: outputs must clear without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    #1 rst_n = 1'b1;
    req = 4'b0101;
    for (int i = 0; i < 10; i++) cycle();

    // General entry without space, uni exit with empty zone, then all four held.
    req = 4'b0010;
    for (int i = 0; i < 4; i++) cycle();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) cycle();
    uni_cnt = 10'd1;
    for (int i = 0; i < 8; i++) cycle();
    req = 4'b1111; uni_vac = 1'b1; gen_vac = 1'b1; uni_cnt = 10'd3; gen_cnt = 10'd7;
    for (int i = 0; i < 40; i++) cycle();

    // Withdrawal during check leaves the pointer unchanged.
    req = 4'b0000;
    for (int i = 0; i < 8; i++) cycle();
    req = 4'b0010;
    cycle();
    req = 4'b0000;
    cycle();
    req = 4'b0011;
    for (int i = 0; i < 10; i++) cycle();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
